// File: rtl/inv_s00_axi_regs_pkg.sv
// Shared constants and types for the inv peripheral's S00_AXI register block.
package inv_s00_axi_regs_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t       RESP_OKAY   = 2'b00;
  localparam resp_t       RESP_SLVERR = 2'b10;
  localparam int unsigned NUM_REGS    = 4;

  typedef logic [1:0] reg_idx_t;

endpackage

// File: rtl/inv_s00_axi_regs_if.sv
// AXI4-Lite bus bundle for the S00_AXI port; master drives requests, slave responds.
interface inv_s00_axi_regs_if
  import inv_s00_axi_regs_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) ();

  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  resp_t           bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  resp_t           rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/inv_s00_axi_regs.sv
// Four 32-bit AXI4-Lite registers plus ~reg1. Define INV_SLVERR_EN to reject
// addresses above 0xF with SLVERR instead of aliasing them onto the registers.
module inv_s00_axi_regs
  import inv_s00_axi_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_areset,
  inv_s00_axi_regs_if.slave                      s00_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          inv_out
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB = DW / 8;

  logic            live_q;
  logic            aw_held_q, aw_held_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            w_held_q, w_held_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [NB-1:0]   w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d;
  resp_t           bresp_q, bresp_d;
  logic [DW-1:0]   regs_q [NUM_REGS];
  logic [DW-1:0]   regs_d [NUM_REGS];
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  resp_t           rresp_q, rresp_d;
  logic            wr_err, rd_err;
  logic            aw_hs, w_hs, ar_hs;
  reg_idx_t        w_idx, r_idx;

`ifdef INV_SLVERR_EN
  if (AW > 4) begin : g_err
    assign wr_err = |aw_addr_q[AW-1:4];
    assign rd_err = |s00_axi.araddr[AW-1:4];
  end else begin : g_no_err
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
  end
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Ready stays low until the first edge after reset release.
  assign s00_axi.awready = live_q & ~aw_held_q & ~bvalid_q;
  assign s00_axi.wready  = live_q & ~w_held_q & ~bvalid_q;
  assign s00_axi.arready = live_q & ~rvalid_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;

  assign aw_hs = s00_axi.awvalid & s00_axi.awready;
  assign w_hs  = s00_axi.wvalid & s00_axi.wready;
  assign ar_hs = s00_axi.arvalid & s00_axi.arready;
  assign w_idx = reg_idx_t'(aw_addr_q[3:2]);
  assign r_idx = reg_idx_t'(s00_axi.araddr[3:2]);

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s00_axi.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi.wdata;
      w_strb_d = s00_axi.wstrb;
    end
    if (aw_held_q && w_held_q && !bvalid_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
      if (!wr_err) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (w_strb_q[i]) regs_d[w_idx][8*i +: 8] = w_data_q[8*i +: 8];
        end
      end
    end else if (bvalid_q && s00_axi.bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      live_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? '0 : regs_q[r_idx];
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s00_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign reg_out = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign inv_out = ~regs_q[1];

  logic unused_ok;
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, aw_addr_q, s00_axi.araddr};

endmodule
